// File: rtl/avl_bus_arbiter.sv
// ---------------------------------------------------------------------------
// avl_bus_arbiter
//   Arbitrates MASTER_NUM Avalon-MM burst masters onto one shared slave.
//   The owner keeps the bus for a whole write or read burst. The owner's
//   command is muxed straight onto the s_* ports, and read data is routed
//   back to the owner only.
//
// Configuration macro:
//   AVL_BUS_ARB_ROUND_ROBIN_EN - when defined, priority rotates and starts
//                                at the index after the last owner.
//                                When undefined, priority is fixed and the
//                                lowest index wins.
//
// Ports:
//   clk, rest                 - clock, asynchronous active-high reset
//   m_address .. m_burst_count - per-master command fields (MASTER_NUM wide)
//   m_waitrequest             - per-master stall
//   m_read_data               - shared read data
//   m_read_data_valid         - per-master read data valid
//   s_address .. s_burst_count - command to the shared slave
//   s_waitrequest             - slave stall
//   s_read_data               - slave read data
//   s_read_data_valid         - slave read data valid
//   grant                     - one-hot current owner (all-zero when idle)
// ---------------------------------------------------------------------------
package avl_bus_arbiter_pkg;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned BC_W   = 8;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic [BE_W-1:0]   byte_en;
      logic              read;
      logic              write;
      logic [DATA_W-1:0] write_data;
      logic              begin_burst_transfer;
      logic [BC_W-1:0]   burst_count;
   } avl_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_READ_CMD  = 2'd2,
      ST_READ_DATA = 2'd3
   } arb_state_e;
endpackage

module avl_bus_arbiter
   import avl_bus_arbiter_pkg::*;
#(
   parameter int unsigned MASTER_NUM        = 2,
   parameter int unsigned MAX_PENDING_BEATS = 255
) (
   input  logic                              clk,
   input  logic                              rest,
   input  logic [MASTER_NUM-1:0][ADDR_W-1:0] m_address,
   input  logic [MASTER_NUM-1:0][BE_W-1:0]   m_byte_en,
   input  logic [MASTER_NUM-1:0]             m_read,
   input  logic [MASTER_NUM-1:0]             m_write,
   input  logic [MASTER_NUM-1:0][DATA_W-1:0] m_write_data,
   input  logic [MASTER_NUM-1:0]             m_begin_burst_transfer,
   input  logic [MASTER_NUM-1:0][BC_W-1:0]   m_burst_count,
   output logic [MASTER_NUM-1:0]             m_waitrequest,
   output logic [DATA_W-1:0]                 m_read_data,
   output logic [MASTER_NUM-1:0]             m_read_data_valid,
   output logic [ADDR_W-1:0]                 s_address,
   output logic [BE_W-1:0]                   s_byte_en,
   output logic                              s_read,
   output logic                              s_write,
   output logic [DATA_W-1:0]                 s_write_data,
   output logic                              s_begin_burst_transfer,
   output logic [BC_W-1:0]                   s_burst_count,
   input  logic                              s_waitrequest,
   input  logic [DATA_W-1:0]                 s_read_data,
   input  logic                              s_read_data_valid,
   output logic [MASTER_NUM-1:0]             grant
);

   localparam int unsigned     IDX_W  = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
   localparam logic [BC_W-1:0] MAX_BC = BC_W'(MAX_PENDING_BEATS);

   arb_state_e              state_q, state_d;
   logic [MASTER_NUM-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [BC_W-1:0]         cnt_q, cnt_d;

   logic [MASTER_NUM-1:0]   req;
   logic [IDX_W-1:0]        win;
   logic                    win_vld;
   logic [BC_W-1:0]         win_bc;
   avl_cmd_t                owner_cmd;

`ifdef AVL_BUS_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]        rr_idx;
`endif

   // Owner's command fields; non-owners are never looked at.
   always_comb begin
      owner_cmd.address              = m_address[owner_q];
      owner_cmd.byte_en              = m_byte_en[owner_q];
      owner_cmd.read                 = m_read[owner_q];
      owner_cmd.write                = m_write[owner_q];
      owner_cmd.write_data           = m_write_data[owner_q];
      owner_cmd.begin_burst_transfer = m_begin_burst_transfer[owner_q];
      owner_cmd.burst_count          = m_burst_count[owner_q];
   end

   // Winner selection; descending scan so the highest-priority requester is assigned last.
   always_comb begin
      req     = m_read | m_write;
      win     = '0;
      win_vld = 1'b0;
`ifdef AVL_BUS_ARB_ROUND_ROBIN_EN
      rr_idx  = '0;
      for (int k = int'(MASTER_NUM) - 1; k >= 0; k--) begin
         rr_idx = IDX_W'((int'(rr_ptr_q) + k) % int'(MASTER_NUM));
         if (req[rr_idx]) begin
            win     = rr_idx;
            win_vld = 1'b1;
         end
      end
`else
      for (int k = int'(MASTER_NUM) - 1; k >= 0; k--) begin
         if (req[IDX_W'(k)]) begin
            win     = IDX_W'(k);
            win_vld = 1'b1;
         end
      end
`endif
   end

   // Winner's beat count: 0 means a single beat, and the count is clamped to the accepted maximum.
   always_comb begin
      win_bc = m_burst_count[win];
      if (win_bc == '0) begin
         win_bc = BC_W'(1);
      end else if (win_bc > MAX_BC) begin
         win_bc = MAX_BC;
      end
   end

   // State register and burst bookkeeping.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef AVL_BUS_ARB_ROUND_ROBIN_EN
   // Round-robin pointer: index just after the most recent owner.
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
`ifdef AVL_BUS_ARB_ROUND_ROBIN_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               grant_d      = '0;
               grant_d[win] = 1'b1;
               owner_d      = win;
               cnt_d        = win_bc;
               // Read and write together are served as a write.
               state_d      = m_write[win] ? ST_WRITE : ST_READ_CMD;
`ifdef AVL_BUS_ARB_ROUND_ROBIN_EN
               rr_ptr_d     = (int'(win) == int'(MASTER_NUM) - 1) ? '0 : win + IDX_W'(1);
`endif
            end
         end
         ST_WRITE: begin
            // Owner dropping write only stalls the count; the burst is never aborted.
            if (owner_cmd.write && !s_waitrequest) begin
               if (cnt_q <= BC_W'(1)) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - BC_W'(1);
               end
            end
         end
         ST_READ_CMD: begin
            if (owner_cmd.read && !s_waitrequest) begin
               state_d = ST_READ_DATA;
            end
         end
         ST_READ_DATA: begin
            if (s_read_data_valid) begin
               if (cnt_q <= BC_W'(1)) begin
                  state_d = ST_IDLE;
                  grant_d = '0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - BC_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic: slave command mux, per-master stall and read-data routing.
   always_comb begin
      s_address              = owner_cmd.address;
      s_byte_en              = owner_cmd.byte_en;
      s_write_data           = owner_cmd.write_data;
      s_begin_burst_transfer = owner_cmd.begin_burst_transfer;
      s_burst_count          = owner_cmd.burst_count;
      s_write                = (state_q == ST_WRITE) && owner_cmd.write;
      s_read                 = (state_q == ST_READ_CMD) && owner_cmd.read;

      m_waitrequest = '1;
      if ((state_q == ST_WRITE) || (state_q == ST_READ_CMD)) begin
         m_waitrequest[owner_q] = s_waitrequest;
      end

      // Read beats outside READ_DATA are dropped.
      m_read_data       = s_read_data;
      m_read_data_valid = '0;
      if ((state_q == ST_READ_DATA) && s_read_data_valid) begin
         m_read_data_valid = grant_q;
      end

      grant = grant_q;
   end

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avl_bus_arbiter
//   Directed bench for avl_bus_arbiter with two masters. Expected slave
//   write beats and routed read beats are queued when stimulus is driven.
//   They are popped when the DUT forwards a beat. Grant, stall and strobe
//   behaviour is checked against fixed per-cycle expectations.
// ---------------------------------------------------------------------------
module tb_avl_bus_arbiter;

   localparam int unsigned N = 2;

   logic                 clk = 1'b0;
   logic                 rest;
   logic [N-1:0][31:0]   m_address;
   logic [N-1:0][3:0]    m_byte_en;
   logic [N-1:0]         m_read;
   logic [N-1:0]         m_write;
   logic [N-1:0][31:0]   m_write_data;
   logic [N-1:0]         m_begin_burst_transfer;
   logic [N-1:0][7:0]    m_burst_count;
   logic [N-1:0]         m_waitrequest;
   logic [31:0]          m_read_data;
   logic [N-1:0]         m_read_data_valid;
   logic [31:0]          s_address;
   logic [3:0]           s_byte_en;
   logic                 s_read;
   logic                 s_write;
   logic [31:0]          s_write_data;
   logic                 s_begin_burst_transfer;
   logic [7:0]           s_burst_count;
   logic                 s_waitrequest;
   logic [31:0]          s_read_data;
   logic                 s_read_data_valid;
   logic [N-1:0]         grant;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_exp_t;
   typedef struct { logic [N-1:0] vld; logic [31:0] data; } rd_exp_t;

   wr_exp_t wr_q[$];
   rd_exp_t rd_q[$];

   int checks   = 0;
   int errors   = 0;
   int wr_beats = 0;
   int rd_beats = 0;

   logic [N-1:0] grant_s, mwr_s, mrdv_s;
   logic         sw_s, sr_s;
   logic [31:0]  addr_s;

   always #5 clk = ~clk;

   avl_bus_arbiter #(
      .MASTER_NUM        (N),
      .MAX_PENDING_BEATS (255)
   ) dut (
      .clk                    (clk),
      .rest                   (rest),
      .m_address              (m_address),
      .m_byte_en              (m_byte_en),
      .m_read                 (m_read),
      .m_write                (m_write),
      .m_write_data           (m_write_data),
      .m_begin_burst_transfer (m_begin_burst_transfer),
      .m_burst_count          (m_burst_count),
      .m_waitrequest          (m_waitrequest),
      .m_read_data            (m_read_data),
      .m_read_data_valid      (m_read_data_valid),
      .s_address              (s_address),
      .s_byte_en              (s_byte_en),
      .s_read                 (s_read),
      .s_write                (s_write),
      .s_write_data           (s_write_data),
      .s_begin_burst_transfer (s_begin_burst_transfer),
      .s_burst_count          (s_burst_count),
      .s_waitrequest          (s_waitrequest),
      .s_read_data            (s_read_data),
      .s_read_data_valid      (s_read_data_valid),
      .grant                  (grant)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge, score forwarded beats, then return just after the rising edge.
   task automatic step();
      wr_exp_t we;
      rd_exp_t re;
      @(negedge clk);
      grant_s = grant;
      mwr_s   = m_waitrequest;
      mrdv_s  = m_read_data_valid;
      sw_s    = s_write;
      sr_s    = s_read;
      addr_s  = s_address;
      if (s_write && !s_waitrequest) begin
         wr_beats++;
         chk("wr_beat_expected", 32'(wr_q.size() != 0), 32'd1);
         if (wr_q.size() != 0) begin
            we = wr_q.pop_front();
            chk("wr_addr", s_address, we.addr);
            chk("wr_data", s_write_data, we.data);
         end
      end
      if (m_read_data_valid != '0) begin
         rd_beats++;
         chk("rd_beat_expected", 32'(rd_q.size() != 0), 32'd1);
         if (rd_q.size() != 0) begin
            re = rd_q.pop_front();
            chk("rd_vld", 32'(m_read_data_valid), 32'(re.vld));
            chk("rd_data", m_read_data, re.data);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          held;
      int          bad_wait;
      int          leak;
      logic [1:0]  exp_g [3];

      rest                   = 1'b1;
      m_address              = '0;
      m_byte_en              = '1;
      m_read                 = '0;
      m_write                = '0;
      m_write_data           = '0;
      m_begin_burst_transfer = '0;
      m_burst_count          = '0;
      s_waitrequest          = 1'b0;
      s_read_data            = '0;
      s_read_data_valid      = 1'b0;

      // Reset values
      @(negedge clk);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_mwait", 32'(m_waitrequest), 32'h3);
      chk("rst_mrdv", 32'(m_read_data_valid), 32'h0);
      chk("rst_swrite", 32'(s_write), 32'h0);
      chk("rst_sread", 32'(s_read), 32'h0);
      @(posedge clk);
      #1;
      rest = 1'b0;

      // Single write beat from m0
      m_write[0] = 1'b1; m_address[0] = 32'h8000_0000; m_write_data[0] = 32'hA5A5_0001;
      m_burst_count[0] = 8'd1; m_begin_burst_transfer[0] = 1'b1;
      wr_q.push_back('{32'h8000_0000, 32'hA5A5_0001});
      wr_beats = 0;
      step();
      chk("t1_grant_idle", 32'(grant_s), 32'h0);
      chk("t1_swrite_idle", 32'(sw_s), 32'h0);
      step();
      chk("t1_grant_write", 32'(grant_s), 32'h1);
      chk("t1_swrite", 32'(sw_s), 32'h1);
      chk("t1_mwait", 32'(mwr_s), 32'h2);
      m_write[0] = 1'b0; m_begin_burst_transfer[0] = 1'b0;
      step();
      chk("t1_grant_done", 32'(grant_s), 32'h0);
      chk("t1_swrite_done", 32'(sw_s), 32'h0);
      chk("t1_beats", 32'(wr_beats), 32'd1);

      // Write burst 4, slave stalls two cycles on beat 2
      m_write[0] = 1'b1; m_address[0] = 32'h0000_1000; m_burst_count[0] = 8'd4;
      for (int k = 0; k < 4; k++) wr_q.push_back('{32'h0000_1000, 32'h2000_0000 + 32'(k)});
      wr_beats = 0; held = 0;
      m_write_data[0] = 32'h2000_0000;
      step();
      for (int c = 0; c < 6; c++) begin
         s_waitrequest   = (c == 1) || (c == 2);
         m_write_data[0] = 32'h2000_0000 + 32'(wr_beats);
         step();
         if (grant_s == 2'b01) held++;
         if (c == 1) chk("t2_stall_mwait", 32'(mwr_s[0]), 32'h1);
      end
      s_waitrequest = 1'b0; m_write[0] = 1'b0;
      step();
      chk("t2_beats", 32'(wr_beats), 32'd4);
      chk("t2_grant_held", 32'(held), 32'd6);
      chk("t2_grant_done", 32'(grant_s), 32'h0);
      chk("t2_q_empty", 32'(wr_q.size()), 32'd0);

      // Owner drops write mid-burst: bus held, no abort
      m_write[0] = 1'b1; m_address[0] = 32'h0000_3000; m_burst_count[0] = 8'd2;
      m_write_data[0] = 32'h3000_0000;
      wr_q.push_back('{32'h0000_3000, 32'h3000_0000});
      wr_q.push_back('{32'h0000_3000, 32'h3000_0001});
      wr_beats = 0;
      step();
      step();
      m_write[0] = 1'b0;
      step();
      chk("t2b_grant_hold1", 32'(grant_s), 32'h1);
      chk("t2b_swrite_low", 32'(sw_s), 32'h0);
      step();
      chk("t2b_grant_hold2", 32'(grant_s), 32'h1);
      m_write[0] = 1'b1; m_write_data[0] = 32'h3000_0001;
      step();
      m_write[0] = 1'b0;
      step();
      chk("t2b_grant_done", 32'(grant_s), 32'h0);
      chk("t2b_beats", 32'(wr_beats), 32'd2);

      // Read burst 3 from m1, with stray slave beats outside READ_DATA
      m_read[1] = 1'b1; m_address[1] = 32'h8001_0000; m_burst_count[1] = 8'd3;
      for (int k = 0; k < 3; k++) rd_q.push_back('{2'b10, 32'hC0DE_0000 + 32'(k)});
      rd_beats = 0;
      step();
      chk("t3_grant_idle", 32'(grant_s), 32'h0);
      s_read_data_valid = 1'b1; s_read_data = 32'hDEAD_BEEF;
      step();
      chk("t3_grant", 32'(grant_s), 32'h2);
      chk("t3_sread", 32'(sr_s), 32'h1);
      chk("t3_addr", addr_s, 32'h8001_0000);
      chk("t3_mrdv_cmd", 32'(mrdv_s), 32'h0);
      m_read[1] = 1'b0;
      s_read_data_valid = 1'b1; s_read_data = 32'hC0DE_0000;
      step();
      chk("t3_sread_data", 32'(sr_s), 32'h0);
      chk("t3_mwait_data", 32'(mwr_s), 32'h3);
      s_read_data_valid = 1'b0;
      step();
      s_read_data_valid = 1'b1; s_read_data = 32'hC0DE_0001;
      step();
      s_read_data = 32'hC0DE_0002;
      step();
      s_read_data = 32'hDEAD_0001;
      step();
      chk("t3_mrdv_idle", 32'(mrdv_s), 32'h0);
      chk("t3_grant_done", 32'(grant_s), 32'h0);
      chk("t3_beats", 32'(rd_beats), 32'd3);
      chk("t3_q_empty", 32'(rd_q.size()), 32'd0);
      s_read_data_valid = 1'b0;

      // Both masters request continuously
`ifdef AVL_BUS_ARB_ROUND_ROBIN_EN
      exp_g = '{2'b01, 2'b10, 2'b01};
`else
      exp_g = '{2'b01, 2'b01, 2'b01};
`endif
      m_address[0] = 32'h0000_00A0; m_write_data[0] = 32'hD000_000A; m_burst_count[0] = 8'd1;
      m_address[1] = 32'h0000_00B0; m_write_data[1] = 32'hD000_000B; m_burst_count[1] = 8'd1;
      for (int c = 0; c < 3; c++) begin
         if (exp_g[c] == 2'b01) wr_q.push_back('{32'h0000_00A0, 32'hD000_000A});
         else                   wr_q.push_back('{32'h0000_00B0, 32'hD000_000B});
      end
      m_write = 2'b11;
      for (int c = 0; c < 3; c++) begin
         step();
         step();
         chk($sformatf("t4_grant%0d", c), 32'(grant_s), 32'(exp_g[c]));
      end
      m_write = 2'b00;
      step();
      chk("t4_grant_done", 32'(grant_s), 32'h0);
      chk("t4_q_empty", 32'(wr_q.size()), 32'd0);

      // m1 requests during an 8-beat m0 write burst
      m_write[0] = 1'b1; m_address[0] = 32'h0000_4000; m_burst_count[0] = 8'd8;
      for (int k = 0; k < 8; k++) wr_q.push_back('{32'h0000_4000, 32'h4000_0000 + 32'(k)});
      wr_q.push_back('{32'h0000_5000, 32'h5000_0000});
      wr_beats = 0;
      m_write_data[0] = 32'h4000_0000;
      step();
      m_write[1] = 1'b1; m_address[1] = 32'h0000_5000; m_burst_count[1] = 8'd1;
      m_write_data[1] = 32'h5000_0000;
      bad_wait = 0; held = 0;
      for (int c = 0; c < 8; c++) begin
         m_write_data[0] = 32'h4000_0000 + 32'(wr_beats);
         step();
         if (mwr_s[1] !== 1'b1) bad_wait++;
         if (grant_s == 2'b01) held++;
      end
      m_write[0] = 1'b0;
      chk("t5_m1_wait", 32'(bad_wait), 32'd0);
      chk("t5_m0_held", 32'(held), 32'd8);
      chk("t5_m0_beats", 32'(wr_beats), 32'd8);
      step();
      chk("t5_grant_idle", 32'(grant_s), 32'h0);
      chk("t5_m1_wait_idle", 32'(mwr_s[1]), 32'h1);
      step();
      chk("t5_grant_m1", 32'(grant_s), 32'h2);
      chk("t5_swrite_m1", 32'(sw_s), 32'h1);
      chk("t5_addr_m1", addr_s, 32'h0000_5000);
      chk("t5_mwait_m1", 32'(mwr_s), 32'h1);
      m_write[1] = 1'b0;
      step();
      chk("t5_grant_done", 32'(grant_s), 32'h0);
      chk("t5_q_empty", 32'(wr_q.size()), 32'd0);

      // Reset during READ_DATA after 1 of 4 beats
      m_read[0] = 1'b1; m_address[0] = 32'h0000_6000; m_burst_count[0] = 8'd4;
      rd_q.push_back('{2'b01, 32'h6000_0000});
      rd_beats = 0;
      step();
      step();
      chk("t6_sread", 32'(sr_s), 32'h1);
      m_read[0] = 1'b0;
      s_read_data_valid = 1'b1; s_read_data = 32'h6000_0000;
      step();
      chk("t6_mrdv_first", 32'(mrdv_s), 32'h1);
      rest = 1'b1; s_read_data = 32'h6000_0001;
      #1;
      chk("t6_rst_grant_now", 32'(grant), 32'h0);
      chk("t6_rst_mrdv_now", 32'(m_read_data_valid), 32'h0);
      step();
      chk("t6_rst_grant", 32'(grant_s), 32'h0);
      chk("t6_rst_mwait", 32'(mwr_s), 32'h3);
      chk("t6_rst_sread", 32'(sr_s), 32'h0);
      chk("t6_rst_swrite", 32'(sw_s), 32'h0);
      rest = 1'b0;
      leak = 0;
      for (int c = 0; c < 3; c++) begin
         s_read_data = 32'h6000_0002 + 32'(c);
         step();
         if (mrdv_s != '0) leak++;
      end
      s_read_data_valid = 1'b0;
      chk("t6_no_leak", 32'(leak), 32'd0);
      chk("t6_beats", 32'(rd_beats), 32'd1);
      chk("t6_grant_after", 32'(grant_s), 32'h0);
      chk("t6_q_empty", 32'(rd_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/avl_bus_arbiter.md
AVL_BUS_ARBITER -- requirements
Module: avl_bus_arbiter

Interface
REQ-001 SHALL have parameter MASTER_NUM, default 2, number of requesting masters (legal range 2..8).
REQ-002 SHALL have parameter MAX_PENDING_BEATS, default 255, the largest burst_count accepted (8-bit field).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rest  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports m_address/m_byte_en/m_read/m_write/m_write_data/m_begin_burst_transfer/m_burst_count  in  MASTER_NUM x (32/4/1/1/32/1/8)  per-master command fields (avl_cmd_t layout).
REQ-006 SHALL have ports m_waitrequest  out  MASTER_NUM; m_read_data  out  32 (shared); m_read_data_valid  out  MASTER_NUM.
REQ-007 SHALL have ports s_address/s_byte_en/s_read/s_write/s_write_data/s_begin_burst_transfer/s_burst_count  out  32/4/1/1/32/1/8  to the shared slave.
REQ-008 SHALL have ports s_waitrequest  in  1; s_read_data  in  32; s_read_data_valid  in  1.
REQ-009 SHALL have port grant  out  MASTER_NUM  one-hot current owner (all-zero when idle).

Function
REQ-010 SHALL use states IDLE, WRITE, READ_CMD, READ_DATA.
REQ-011 In IDLE, a request is m_read[i] or m_write[i] high; the winner SHALL be selected combinationally and grant registered, so the first slave command appears 1 cycle after request.
REQ-012 IDLE -> WRITE if winner asserts write, -> READ_CMD if read; a master asserting both SHALL be treated as write.
REQ-013 Owner's command fields SHALL be muxed to s_* ports; non-owners' fields ignored; s_read/s_write low in IDLE and READ_DATA.
REQ-014 m_waitrequest[i] SHALL equal s_waitrequest for the owner while it is in WRITE/READ_CMD, and 1 for every non-owner and in IDLE/READ_DATA.
REQ-015 Beat counter SHALL load the owner's burst_count on entry; burst_count 0 SHALL be treated as 1.
REQ-016 WRITE: counter decrements on each cycle s_write & !s_waitrequest; on last beat -> IDLE, grant cleared same edge.
REQ-017 READ_CMD: on s_read & !s_waitrequest -> READ_DATA.
REQ-018 READ_DATA: m_read_data = s_read_data; m_read_data_valid[owner] = s_read_data_valid; counter decrements per valid beat; last beat -> IDLE.
REQ-019 Grant SHALL NOT change mid-burst regardless of other requests; a new grant is possible the cycle after returning to IDLE.
REQ-020 s_read_data_valid in IDLE/WRITE/READ_CMD SHALL be dropped (no m_read_data_valid asserted).
REQ-021 Owner deasserting read/write mid-WRITE SHALL stall the counter (no abort); arbiter remains in WRITE.

Reset
REQ-022 On rest high, immediately: state IDLE, grant 0, counter 0, round-robin pointer to master 0; s_read/s_write 0, all m_waitrequest 1, m_read_data_valid 0.
REQ-023 Reset mid-burst SHALL abandon the transfer with no further beats forwarded after rest deasserts.

Configuration
REQ-024 With AVL_BUS_ARB_ROUND_ROBIN_EN defined, priority SHALL start at the index after the last owner, wrapping MASTER_NUM-1 -> 0.
REQ-025 Without AVL_BUS_ARB_ROUND_ROBIN_EN, fixed priority SHALL apply, lowest index wins; no pointer register.

Verification
REQ-026 Single write: m0 write addr 0x80000000 burst 1, s_waitrequest 0 -> s_write 1 one cycle, grant 01 then 00.
REQ-027 Write burst 4 with s_waitrequest high on beat 2 for 2 cycles -> exactly 4 accepted beats, counter stalls, grant held 6 cycles.
REQ-028 Read burst 3: m1 read addr 0x80010000 -> one s_read accept, 3 s_read_data_valid beats routed only to m_read_data_valid[1], then IDLE.
REQ-029 Both masters request continuously, round-robin on -> grants alternate 01,10,01; macro off -> m0 always wins.
REQ-030 m1 requests during m0 write burst 8 -> m1 waitrequest stays 1 until m0's 8th beat, m1 granted next cycle.
REQ-031 rest pulsed during READ_DATA after 1 of 4 beats -> outputs at reset values same cycle, later s_read_data_valid not forwarded.
